// File: rtl/ycbcr2rgb.sv
// BT.601 YCbCr 4:4:4 to 8-bit RGB, 3-stage pipeline, one pixel per clock.
// Define YCBCR2RGB_STUDIO_RANGE_EN for studio-range input (Y 16..235, C 16..240).
module ycbcr2rgb #(
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned COEF_W = 18
) (
   input  logic             i_pclk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [7:0]       i_Y,
   input  logic [7:0]       i_Cb,
   input  logic [7:0]       i_Cr,
   input  logic [TAG_W-1:0] i_tags,
   output logic             o_valid,
   output logic [7:0]       o_R,
   output logic [7:0]       o_G,
   output logic [7:0]       o_B,
   output logic [TAG_W-1:0] o_tags
);

   localparam int unsigned CW     = COEF_W + 1;   // signed coefficient width
   localparam int unsigned PROD_W = CW + 9;       // coefficient x signed 9-bit operand
   localparam int unsigned ACC_W  = PROD_W + 2;   // headroom for the summed G terms
   localparam int unsigned SUM_W  = 11;

`ifdef YCBCR2RGB_STUDIO_RANGE_EN
   localparam logic signed [CW-1:0] KY  = CW'(76309);
   localparam logic signed [CW-1:0] KR  = CW'(104597);
   localparam logic signed [CW-1:0] KGB = CW'(25675);
   localparam logic signed [CW-1:0] KGR = CW'(53279);
   localparam logic signed [CW-1:0] KB  = CW'(132201);
`else
   localparam logic signed [CW-1:0] KR  = CW'(91881);
   localparam logic signed [CW-1:0] KGB = CW'(22554);
   localparam logic signed [CW-1:0] KGR = CW'(46802);
   localparam logic signed [CW-1:0] KB  = CW'(116130);
`endif
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(32768);

   logic                     v1, v2;
   logic signed [8:0]        y1, dcb, dcr;
   logic [TAG_W-1:0]         tags1, tags2;
   logic signed [PROD_W-1:0] pr, pgb, pgr, pb;
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
   logic signed [PROD_W-1:0] py;
`else
   logic signed [8:0]        y2;
`endif
   logic signed [ACC_W-1:0]  base_c, r_acc_c, g_acc_c, b_acc_c;
   logic signed [SUM_W-1:0]  r_sum_c, g_sum_c, b_sum_c;

   // Clamp a signed channel sum into 0..255
   function automatic logic [7:0] sat8(input logic signed [SUM_W-1:0] x);
      if (x[SUM_W-1])
         return 8'd0;
      else if (|x[SUM_W-2:8])
         return 8'hFF;
      return x[7:0];
   endfunction

   // Stage 1: remove offsets; invalid cycles load zeros
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v1    <= 1'b0;
         y1    <= '0;
         dcb   <= '0;
         dcr   <= '0;
         tags1 <= '0;
      end else begin
         v1 <= i_valid;
         if (i_valid) begin
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
            y1 <= $signed({1'b0, i_Y}) - 9'sd16;
`else
            y1 <= $signed({1'b0, i_Y});
`endif
            dcb   <= $signed({1'b0, i_Cb}) - 9'sd128;
            dcr   <= $signed({1'b0, i_Cr}) - 9'sd128;
            tags1 <= i_tags;
         end else begin
            y1    <= '0;
            dcb   <= '0;
            dcr   <= '0;
            tags1 <= '0;
         end
      end
   end

   // Stage 2: coefficient products
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v2    <= 1'b0;
         tags2 <= '0;
         pr    <= '0;
         pgb   <= '0;
         pgr   <= '0;
         pb    <= '0;
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
         py    <= '0;
`else
         y2    <= '0;
`endif
      end else begin
         v2    <= v1;
         tags2 <= tags1;
         pr    <= PROD_W'(KR)  * PROD_W'(dcr);
         pgb   <= PROD_W'(KGB) * PROD_W'(dcb);
         pgr   <= PROD_W'(KGR) * PROD_W'(dcr);
         pb    <= PROD_W'(KB)  * PROD_W'(dcb);
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
         py    <= PROD_W'(KY)  * PROD_W'(y1);
`else
         y2    <= y1;
`endif
      end
   end

   // Stage 3 arithmetic: round-offset, floor shift, add luma
   always_comb begin
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
      base_c  = ACC_W'(py) + RND;
`else
      base_c  = RND;
`endif
      r_acc_c = base_c + ACC_W'(pr);
      g_acc_c = base_c - ACC_W'(pgb) - ACC_W'(pgr);
      b_acc_c = base_c + ACC_W'(pb);
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
      r_sum_c = SUM_W'(r_acc_c >>> 16);
      g_sum_c = SUM_W'(g_acc_c >>> 16);
      b_sum_c = SUM_W'(b_acc_c >>> 16);
`else
      r_sum_c = SUM_W'(r_acc_c >>> 16) + SUM_W'(y2);
      g_sum_c = SUM_W'(g_acc_c >>> 16) + SUM_W'(y2);
      b_sum_c = SUM_W'(b_acc_c >>> 16) + SUM_W'(y2);
`endif
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_R     <= '0;
         o_G     <= '0;
         o_B     <= '0;
         o_tags  <= '0;
      end else begin
         o_valid <= v2;
         o_R     <= sat8(r_sum_c);
         o_G     <= sat8(g_sum_c);
         o_B     <= sat8(b_sum_c);
         o_tags  <= tags2;
      end
   end

endmodule
